pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core (F, D, E, M, W). Tracks destination registers of in-flight instructions, generates registered forwarding selects for the E-stage operand muxes, and drives stall, bubble and flush controls for load-use hazards, taken branches and data-memory wait states. It sits beside the decoder in D and replaces the decoder's internal last/penultimate-rd bookkeeping with a properly clocked scoreboard. It also keeps saturating stall and flush event counters.

---
 rtl/rv32_pkg.sv | 29 ++
 rtl/rv_opclass.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: opcode[6:2] classes, forwarding encodings
// and the hazard scoreboard slot type.
package rv32_pkg;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b10;
  localparam logic [1:0] FWD_MWB = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] rd;
  } sb_slot_t;

  // x0 is never a real producer, so it never matches.
  function automatic logic slot_match(input sb_slot_t s, input logic [4:0] src);
    return s.valid && s.wr && (s.rd != 5'd0) && (s.rd == src);
  endfunction
endpackage

// File: rtl/rv_opclass.sv
// Opcode[6:2] classifier: which register fields an instruction reads/writes.
module rv_opclass
  import rv32_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       writes_rd_o,
  output logic       is_load_o
);
  always_comb begin
    uses_rs1_o  = 1'b0;
    uses_rs2_o  = 1'b0;
    writes_rd_o = 1'b0;
    is_load_o   = 1'b0;
    case (opcode_i)
      OP_R:      begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
      OP_IMM:    begin uses_rs1_o = 1'b1; writes_rd_o = 1'b1; end
      OP_LOAD:   begin uses_rs1_o = 1'b1; writes_rd_o = 1'b1; is_load_o = 1'b1; end
      OP_STORE:  begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
      OP_BRANCH: begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
      OP_JALR:   begin uses_rs1_o = 1'b1; writes_rd_o = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: writes_rd_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage RV32 hazard controller: E/M rd scoreboard, registered forwarding
// selects, stall/flush/bubble controls and saturating event counters.
module pipe_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_d,
  input  logic             valid_d,
  input  logic             branch_taken_e,
  input  logic             dmem_wait,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             bubble_e,
  output logic [1:0]       fwd_rs1_e,
  output logic [1:0]       fwd_rs2_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic       use1, use2, load_use;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] fwd1_d, fwd2_d;
  sb_slot_t   e_q, e_d, m_q;
  logic [1:0] fwd1_q, fwd2_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  rv_opclass u_cls (
    .opcode_i   (instr_d[6:2]),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .writes_rd_o(writes_rd),
    .is_load_o  (is_load)
  );

  assign rs1  = instr_d[19:15];
  assign rs2  = instr_d[24:20];
  assign rd   = instr_d[11:7];
  assign use1 = valid_d && uses_rs1;
  assign use2 = valid_d && uses_rs2;

  // E slot holds the newer write, so it takes precedence over M.
  function automatic logic [1:0] fwd_sel(input logic used, input sb_slot_t e,
                                         input sb_slot_t m, input logic [4:0] src);
    if (!used)                return FWD_REG;
    else if (slot_match(e, src)) return FWD_EXM;
    else if (slot_match(m, src)) return FWD_MWB;
    else                      return FWD_REG;
  endfunction

  assign fwd1_d   = fwd_sel(use1, e_q, m_q, rs1);
  assign fwd2_d   = fwd_sel(use2, e_q, m_q, rs2);
  assign load_use = e_q.load && ((use1 && slot_match(e_q, rs1)) ||
                                 (use2 && slot_match(e_q, rs2)));

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    if (!rst_n) begin
    end else if (dmem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (branch_taken_e) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  always_comb begin
    e_d = '0;
    if (!bubble_e && valid_d) begin
      e_d.valid = 1'b1;
      e_d.wr    = writes_rd;
      e_d.load  = is_load;
      e_d.rd    = rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= '0;
      m_q         <= '0;
      fwd1_q      <= FWD_REG;
      fwd2_q      <= FWD_REG;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!dmem_wait) begin
      m_q    <= e_q;
      e_q    <= e_d;
      fwd1_q <= e_d.valid ? fwd1_d : FWD_REG;
      fwd2_q <= e_d.valid ? fwd2_d : FWD_REG;
      if (branch_taken_e && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (!branch_taken_e && load_use && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_rs1_e = fwd1_q;
  assign fwd_rs2_e = fwd2_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each step pushes its expected controls,
// forwarding selects and counts; they are popped and compared as the DUT responds.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        valid_d, branch_taken_e, dmem_wait;
  logic        stall_f, stall_d, flush_d, bubble_e;
  logic [1:0]  fwd_rs1_e, fwd_rs2_e;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_sf, s_sd, s_fd, s_be;
  logic [1:0]  s_f1, s_f2;
  logic [3:0]  s_sc, s_fc;

  int errs = 0, checks = 0;
  int esc = 0, efc = 0;

  typedef struct {
    logic [3:0] ctrl;
    logic [1:0] f1, f2;
    int         sc, fc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .dmem_wait(dmem_wait),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble_e(bubble_e),
    .fwd_rs1_e(fwd_rs1_e), .fwd_rs2_e(fwd_rs2_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow counters so saturation is reachable in a short run.
  pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .branch_taken_e(branch_taken_e), .dmem_wait(dmem_wait),
    .stall_f(s_sf), .stall_d(s_sd), .flush_d(s_fd), .bubble_e(s_be),
    .fwd_rs1_e(s_f1), .fwd_rs2_e(s_f2),
    .stall_cnt(s_sc), .flush_cnt(s_fc)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input int rd, rs1, rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] addi(input int rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input int rd, rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] beq(input int rs1, rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'd8, 7'b1100011};
  endfunction

  // Called just after a negedge; controls checked before the posedge,
  // registered outputs checked just after it.
  task automatic step(input logic [31:0] ins, input logic br, input logic w,
                      input logic [3:0] ctrl, input logic [1:0] f1, input logic [1:0] f2,
                      input string tag);
    exp_t e, got;
    instr_d = ins; valid_d = 1'b1; branch_taken_e = br; dmem_wait = w;
    if (!w && ctrl == 4'b1101) esc++;
    if (!w && ctrl == 4'b0011) efc++;
    e.ctrl = ctrl; e.f1 = f1; e.f2 = f2; e.sc = esc; e.fc = efc;
    q.push_back(e);
    #2;
    got = q.pop_front();
    chk({tag, ".ctrl"}, {stall_f, stall_d, flush_d, bubble_e}, got.ctrl);
    @(posedge clk); #1;
    chk({tag, ".fwd1"}, fwd_rs1_e, got.f1);
    chk({tag, ".fwd2"}, fwd_rs2_e, got.f2);
    chk({tag, ".scnt"}, stall_cnt, got.sc);
    chk({tag, ".fcnt"}, flush_cnt, got.fc);
    @(negedge clk);
  endtask

  task automatic drain();
    step(addi(0, 0, 0), 0, 0, 4'b0000, 2'b00, 2'b00, "nop");
    step(addi(0, 0, 0), 0, 0, 4'b0000, 2'b00, 2'b00, "nop");
  endtask

  initial begin
    rst_n = 1'b0; instr_d = '0; valid_d = 1'b0; branch_taken_e = 1'b1; dmem_wait = 1'b0;
    #2;
    chk("rst.ctrl", {stall_f, stall_d, flush_d, bubble_e}, 0);
    chk("rst.fwd", {fwd_rs1_e, fwd_rs2_e}, 0);
    chk("rst.cnt", {stall_cnt, flush_cnt}, 0);
    branch_taken_e = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // E-slot forward
    step(r_op(5, 1, 2), 0, 0, 4'b0000, 2'b00, 2'b00, "ex.add5");
    step(r_op(6, 5, 3), 0, 0, 4'b0000, 2'b10, 2'b00, "ex.add6");
    drain();
    // M-slot forward, then E wins over M
    step(r_op(5, 1, 2), 0, 0, 4'b0000, 2'b00, 2'b00, "mw.add5");
    step(addi(0, 0, 0), 0, 0, 4'b0000, 2'b00, 2'b00, "mw.nop");
    step(r_op(7, 3, 5), 0, 0, 4'b0000, 2'b00, 2'b11, "mw.sub");
    drain();
    step(r_op(5, 1, 2), 0, 0, 4'b0000, 2'b00, 2'b00, "pri.add5a");
    step(r_op(5, 1, 2), 0, 0, 4'b0000, 2'b00, 2'b00, "pri.add5b");
    step(r_op(7, 3, 5), 0, 0, 4'b0000, 2'b00, 2'b10, "pri.sub");
    drain();
    // load-use: one stall then M forward on both sources
    step(lw(5, 1), 0, 0, 4'b0000, 2'b00, 2'b00, "lu.lw");
    step(r_op(6, 5, 5), 0, 0, 4'b1101, 2'b00, 2'b00, "lu.stall");
    step(r_op(6, 5, 5), 0, 0, 4'b0000, 2'b11, 2'b11, "lu.go");
    drain();
    // x0 never forwards
    step(addi(0, 1, 1), 0, 0, 4'b0000, 2'b00, 2'b00, "x0.addi");
    step(r_op(2, 0, 0), 0, 0, 4'b0000, 2'b00, 2'b00, "x0.add");
    // branch overrides load-use
    step(lw(5, 1), 0, 0, 4'b0000, 2'b00, 2'b00, "br.lw");
    step(r_op(6, 5, 5), 1, 0, 4'b0011, 2'b00, 2'b00, "br.flush");
    drain();
    // freeze over a pending load-use
    step(r_op(1, 2, 3), 0, 0, 4'b0000, 2'b00, 2'b00, "fz.add1");
    step(lw(5, 1), 0, 0, 4'b0000, 2'b10, 2'b00, "fz.lw");
    for (int i = 0; i < 3; i++)
      step(r_op(6, 5, 5), 0, 1, 4'b1100, 2'b10, 2'b00, "fz.wait");
    step(r_op(6, 5, 5), 0, 0, 4'b1101, 2'b00, 2'b00, "fz.stall");
    step(r_op(6, 5, 5), 0, 0, 4'b0000, 2'b11, 2'b11, "fz.go");
    drain();
    // async reset in the middle of a load-use stall
    step(r_op(1, 2, 3), 0, 0, 4'b0000, 2'b00, 2'b00, "ar.add1");
    step(lw(5, 1), 0, 0, 4'b0000, 2'b10, 2'b00, "ar.lw");
    instr_d = r_op(6, 5, 5);
    #2;
    chk("ar.pre", {stall_f, stall_d, flush_d, bubble_e}, 4'b1101);
    rst_n = 1'b0;
    #1;
    chk("ar.ctrl", {stall_f, stall_d, flush_d, bubble_e}, 0);
    chk("ar.fwd", {fwd_rs1_e, fwd_rs2_e}, 0);
    chk("ar.cnt", {stall_cnt, flush_cnt}, 0);
    esc = 0; efc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(r_op(6, 5, 5), 0, 0, 4'b0000, 2'b00, 2'b00, "ar.after");
    // saturation: 20 stalls and 20 flushes against a 4-bit copy
    for (int i = 0; i < 20; i++) begin
      step(lw(5, 5), 0, 0, 4'b0000, (i == 0) ? 2'b00 : 2'b11, 2'b00, "sat.lw");
      step(lw(5, 5), 0, 0, 4'b1101, 2'b00, 2'b00, "sat.stall");
    end
    for (int i = 0; i < 20; i++)
      step(beq(1, 2), 1, 0, 4'b0011, 2'b00, 2'b00, "sat.flush");
    chk("sat.scnt4", s_sc, 15);
    chk("sat.fcnt4", s_fc, 15);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
